// File: rtl/corelet_ctrl.sv
// corelet_ctrl: start/done sequencer for one convolution tile on the corelet.
// Stages xmem into L0, loads/executes the array, drains psums to pmem, then accumulates via SFP.
module corelet_ctrl #(
  parameter int unsigned row      = 8,
  parameter int unsigned col      = 8,
  parameter int unsigned in_w     = 6,
  parameter int unsigned k_w      = 3,
  parameter int unsigned load_lat = row + col,
  parameter int unsigned xaddr_bw = 11,
  parameter int unsigned paddr_bw = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                l0_full,
  input  logic                ofifo_valid,
  output logic                xmem_cen,
  output logic                xmem_wen,
  output logic [xaddr_bw-1:0] xmem_addr,
  output logic                l0_wr,
  output logic                l0_rd,
  output logic                load,
  output logic                execute,
  output logic                ofifo_rd,
  output logic                pmem_cen,
  output logic                pmem_wen,
  output logic [paddr_bw-1:0] pmem_addr,
  output logic                acc,
  output logic                sfp_clr,
  output logic                relu
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] c_col   = CW'(col);
  localparam logic [CW-1:0] c_in_w  = CW'(in_w);
  localparam logic [CW-1:0] c_k_w   = CW'(k_w);
  localparam logic [CW-1:0] c_out_w = CW'(in_w - k_w + 1);
  localparam logic [CW-1:0] n_len   = CW'(in_w * in_w);
  localparam logic [CW-1:0] k_len   = CW'(k_w * k_w);
  localparam logic [CW-1:0] o_len   = CW'((in_w - k_w + 1) * (in_w - k_w + 1));
  localparam logic [CW-1:0] c_lat   = CW'(load_lat);
  localparam logic [CW-1:0] one     = CW'(1);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StWL0   = 4'd1;
  localparam logic [3:0] StKLoad = 4'd2;
  localparam logic [3:0] StAL0   = 4'd3;
  localparam logic [3:0] StExec  = 4'd4;
  localparam logic [3:0] StDrain = 4'd5;
  localparam logic [3:0] StAcc   = 4'd6;
  localparam logic [3:0] StWrite = 4'd7;
  localparam logic [3:0] StDone  = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] kij_q, kij_d, idx_q, idx_d, o_q, o_d;
  logic [CW-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] rows, xbase;
  logic          stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      kij_q   <= '0;
      idx_q   <= '0;
      o_q     <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kij_q   <= kij_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      pend_q  <= pend_d;
    end
  end

  // pend_q: the row read last cycle is on the xmem output and still owed to L0
  always_comb begin
    rows  = (state_q == StWL0) ? c_col : n_len;
    xbase = (state_q == StWL0) ? n_len + kij_q * c_col : '0;
    stall = pend_q & l0_full;
  end

  always_comb begin
    state_d   = state_q;
    kij_d     = kij_q;
    idx_d     = idx_q;
    o_d       = o_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    pend_d    = pend_q;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    xmem_cen  = 1'b1;
    xmem_wen  = 1'b1;
    xmem_addr = '0;
    l0_wr     = 1'b0;
    l0_rd     = 1'b0;
    load      = 1'b0;
    execute   = 1'b0;
    ofifo_rd  = 1'b0;
    pmem_cen  = 1'b1;
    pmem_wen  = 1'b1;
    pmem_addr = '0;
    acc       = 1'b0;
    sfp_clr   = 1'b0;
    relu      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWL0;
          kij_d   = '0;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      StWL0, StAL0: begin
        l0_wr = pend_q & ~l0_full;
        if (stall) begin
          // re-read the owed row so the SRAM output still carries it next cycle
          xmem_cen  = 1'b0;
          xmem_addr = xaddr_bw'(xbase + idx_q - one);
        end else if (idx_q != rows) begin
          xmem_cen  = 1'b0;
          xmem_addr = xaddr_bw'(xbase + idx_q);
          idx_d     = idx_q + one;
          pend_d    = 1'b1;
        end else begin
          pend_d = 1'b0;
          if (pend_q) begin
            idx_d   = '0;
            state_d = (state_q == StWL0) ? StKLoad : StExec;
          end
        end
      end
      StKLoad: begin
        load  = 1'b1;
        l0_rd = (idx_q < c_col);
        idx_d = idx_q + one;
        if (idx_q == c_lat - one) begin
          idx_d   = '0;
          state_d = StAL0;
        end
      end
      StExec: begin
        l0_rd   = 1'b1;
        execute = 1'b1;
        idx_d   = idx_q + one;
        if (idx_q == n_len - one) begin
          idx_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (ofifo_valid) begin
          ofifo_rd  = 1'b1;
          pmem_cen  = 1'b0;
          pmem_wen  = 1'b0;
          pmem_addr = paddr_bw'(kij_q * n_len + idx_q);
          idx_d     = idx_q + one;
          if (idx_q == n_len - one) begin
            idx_d = '0;
            if (kij_q == k_len - one) begin
              kij_d   = '0;
              o_d     = '0;
              ox_d    = '0;
              oy_d    = '0;
              kx_d    = '0;
              ky_d    = '0;
              state_d = StAcc;
            end else begin
              kij_d   = kij_q + one;
              state_d = StWL0;
            end
          end
        end
      end
      StAcc: begin
        // step 0 clears, steps 1..len_kij read, acc trails each read by one cycle
        sfp_clr = (idx_q == '0);
        acc     = (idx_q >= CW'(2));
        if (idx_q != '0 && idx_q <= k_len) begin
          pmem_cen  = 1'b0;
          pmem_addr = paddr_bw'(kij_q * n_len + (oy_q + ky_q) * c_in_w + ox_q + kx_q);
          kij_d     = kij_q + one;
          if (kx_q == c_k_w - one) begin
            kx_d = '0;
            ky_d = (ky_q == c_k_w - one) ? '0 : ky_q + one;
          end else begin
            kx_d = kx_q + one;
          end
        end
        if (idx_q == k_len + one) begin
          idx_d   = '0;
          state_d = StWrite;
        end else begin
          idx_d = idx_q + one;
        end
      end
      StWrite: begin
        pmem_cen  = 1'b0;
        pmem_wen  = 1'b0;
        relu      = 1'b1;
        pmem_addr = paddr_bw'(k_len * n_len + o_q);
        kij_d     = '0;
        kx_d      = '0;
        ky_d      = '0;
        if (o_q == o_len - one) begin
          state_d = StDone;
        end else begin
          o_d     = o_q + one;
          state_d = StAcc;
          if (ox_q == c_out_w - one) begin
            ox_d = '0;
            oy_d = oy_q + one;
          end else begin
            ox_d = ox_q + one;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized and directed runs of corelet_ctrl checked against
// expected address streams built from the tile's loop structure.
module tb_corelet_ctrl;
  localparam int Col = 8, InW = 6, KW = 3, NLen = 36, KLen = 9, OW = 4, OLen = 16;

  logic clk = 1'b0;
  logic rst, start, l0_full, ofifo_valid;
  logic busy, done, xmem_cen, xmem_wen, l0_wr, l0_rd, load, execute, ofifo_rd;
  logic pmem_cen, pmem_wen, acc, sfp_clr, relu;
  logic [10:0] xmem_addr, pmem_addr;

  corelet_ctrl dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .load(load), .execute(execute), .ofifo_rd(ofifo_rd),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .acc(acc), .sfp_clr(sfp_clr), .relu(relu)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_l0[$], exp_pw[$], exp_pr[$];
  bit exp_relu[$];
  int l0_i, pw_i, pr_i;
  int n_load, n_exec, n_l0rd, n_clr, n_acc, n_done, n_busy, done_cyc;
  bit prev_xread = 1'b0, prev_pread = 1'b0;
  int prev_xaddr = 0;
  int mode = 0, full_left = 0;
  bit fired = 1'b0;
  int win_cnt[8];
  int dut_pr53, dut_pw329, dut_first_l0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic build_model();
    exp_l0.delete(); exp_pw.delete(); exp_pr.delete(); exp_relu.delete();
    for (int k = 0; k < KLen; k++) begin
      for (int i = 0; i < Col; i++) exp_l0.push_back(NLen + k * Col + i);
      for (int n = 0; n < NLen; n++) exp_l0.push_back(n);
      for (int n = 0; n < NLen; n++) begin
        exp_pw.push_back(k * NLen + n);
        exp_relu.push_back(1'b0);
      end
    end
    for (int o = 0; o < OLen; o++) begin
      for (int ky = 0; ky < KW; ky++)
        for (int kx = 0; kx < KW; kx++)
          exp_pr.push_back((ky * KW + kx) * NLen + (o / OW + ky) * InW + (o % OW) + kx);
      exp_pw.push_back(KLen * NLen + o);
      exp_relu.push_back(1'b1);
    end
    l0_i = 0; pw_i = 0; pr_i = 0;
    n_load = 0; n_exec = 0; n_l0rd = 0; n_clr = 0; n_acc = 0; n_done = 0; n_busy = 0;
    done_cyc = 0; dut_pr53 = -1; dut_pw329 = -1; dut_first_l0 = -1;
    for (int i = 0; i < 8; i++) win_cnt[i] = 0;
  endtask

  // per-cycle compare against the expected streams and the handshake rules
  always @(negedge clk) begin
    if (!rst) begin
      bit pw, pr, er;
      pw = !pmem_cen && !pmem_wen;
      pr = !pmem_cen && pmem_wen;
      check("xmem_wen_high", int'(xmem_wen), 1);
      if (l0_wr) begin
        check("l0_wr_after_read", int'(prev_xread), 1);
        check("l0_wr_while_full", int'(l0_full), 0);
        check("l0_row_addr", prev_xaddr, (l0_i < exp_l0.size()) ? exp_l0[l0_i] : -1);
        if (l0_i == 0) dut_first_l0 = prev_xaddr;
        if (mode == 2 && prev_xaddr >= 68 && prev_xaddr <= 75) win_cnt[prev_xaddr-68]++;
        l0_i++;
      end
      if (pw) begin
        er = (pw_i < exp_relu.size()) ? exp_relu[pw_i] : 1'b0;
        check("pmem_waddr", int'(pmem_addr), (pw_i < exp_pw.size()) ? exp_pw[pw_i] : -1);
        check("relu_on_write", int'(relu), int'(er));
        check("ofifo_rd_with_psum_write", int'(ofifo_rd), er ? 0 : 1);
        if (pw_i == 329) dut_pw329 = int'(pmem_addr);
        pw_i++;
      end
      if (ofifo_rd) check("ofifo_rd_needs_valid", int'(ofifo_valid), 1);
      if (pr) begin
        check("pmem_raddr", int'(pmem_addr), (pr_i < exp_pr.size()) ? exp_pr[pr_i] : -1);
        if (pr_i == 53) dut_pr53 = int'(pmem_addr);
        pr_i++;
      end
      check("relu_only_on_write", int'(relu & ~pw), 0);
      check("acc_after_read", int'(acc), int'(prev_pread));
      n_load += int'(load); n_exec += int'(execute); n_l0rd += int'(l0_rd);
      n_clr += int'(sfp_clr); n_acc += int'(acc); n_busy += int'(busy);
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_xread = !xmem_cen;
      prev_xaddr = int'(xmem_addr);
      prev_pread = pr;
    end else begin
      prev_xread = 1'b0;
      prev_pread = 1'b0;
    end
  end

  // input driver: mode 0 clean, 1 random, 2 directed l0_full burst + toggling ofifo_valid
  always @(posedge clk) begin
    #1;
    case (mode)
      0: begin l0_full = 1'b0; ofifo_valid = 1'b1; end
      1: begin
        l0_full     = ($urandom_range(3) == 0);
        ofifo_valid = ($urandom_range(9) < 6);
      end
      default: begin
        ofifo_valid = ~ofifo_valid;
        if (full_left == 0 && !fired && !xmem_cen && xmem_addr == 11'd71) begin
          full_left = 3;
          fired     = 1'b1;
        end
        l0_full = (full_left > 0);
        if (full_left > 0) full_left--;
      end
    endcase
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_strobes"}, int'({busy, done, l0_wr, l0_rd, load, execute, ofifo_rd,
                                   acc, sfp_clr, relu}), 0);
    check({tag, "_enables"}, int'({xmem_cen, xmem_wen, pmem_cen, pmem_wen}), 15);
    check({tag, "_xmem_addr"}, int'(xmem_addr), 0);
    check({tag, "_pmem_addr"}, int'(pmem_addr), 0);
  endtask

  task automatic run_tile(input int m, input bit inject, input string tag);
    int s, waited;
    bit injected;
    mode = m;
    build_model();
    @(posedge clk); #1 start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0;
    waited = 0; injected = 1'b0;
    while (n_done == 0 && waited < 8000) begin
      @(posedge clk); #2;
      if (inject && !injected && ofifo_rd) begin
        start = 1'b1; injected = 1'b1;
        @(posedge clk); #2 start = 1'b0;
      end
      waited++;
    end
    check({tag, "_done_seen"}, int'(n_done > 0), 1);
    repeat (5) @(posedge clk);
    #2;
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_idle_after"}, int'(busy), 0);
    check({tag, "_busy_cycles"}, n_busy, done_cyc - s);
    check({tag, "_l0_writes"}, l0_i, KLen * (Col + NLen));
    check({tag, "_pmem_writes"}, pw_i, KLen * NLen + OLen);
    check({tag, "_pmem_reads"}, pr_i, KLen * OLen);
    check({tag, "_load_cycles"}, n_load, KLen * 16);
    check({tag, "_exec_cycles"}, n_exec, KLen * NLen);
    check({tag, "_l0_rd_cycles"}, n_l0rd, KLen * (Col + NLen));
    check({tag, "_sfp_clr"}, n_clr, OLen);
    check({tag, "_acc_pulses"}, n_acc, KLen * OLen);
    if (m == 0) check({tag, "_latency"}, done_cyc - s, 1399);
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b1;
    build_model();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("reset");
    rst = 1'b0;

    run_tile(0, 1'b0, "clean");
    check("first_weight_addr", dut_first_l0, 36);
    check("acc_o5_kij8_raddr", dut_pr53, 309);
    check("write_o5_addr", dut_pw329, 329);

    run_tile(1, 1'b0, "random");

    fired = 1'b0; full_left = 0;
    run_tile(2, 1'b0, "stall");
    check("stall_burst_fired", int'(fired), 1);
    for (int i = 0; i < 8; i++) check($sformatf("kij4_row%0d_writes", i), win_cnt[i], 1);

    // abort mid-EXEC with reset
    mode = 0;
    build_model();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waited = 0;
    while (!execute && waited < 3000) begin
      @(posedge clk); #2;
      waited++;
    end
    check("exec_reached", int'(execute), 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outs("abort");
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #2 check("abort_no_done", n_done, 0);
    check("abort_idle", int'(busy), 0);

    run_tile(0, 1'b1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
